// File: rtl/i2s_rx_multilane_if.sv
// I2S multilane receiver bus bundle.
// Serial pins, FIFO port, SDMA lines and interrupt sources.
interface i2s_rx_multilane_if #(
  parameter int NUM_LANES = 2,
  parameter int FIFO_AW   = 6
);
  logic                 I2S_CLK_i;
  logic                 I2S_WS_CLK_i;
  logic [NUM_LANES-1:0] I2S_DIN_i;
  logic                 enable_i;
  logic                 mono_i;
  logic                 flush_i;
  logic                 ovf_clr_i;
  logic                 fifo_pop_i;
  logic [31:0]          fifo_dat_o;
  logic [FIFO_AW:0]     fifo_lvl_o;
  logic                 SDMA_Req_o;
  logic                 SDMA_Sreq_o;
  logic                 SDMA_Done_i;
  logic                 I2S_RX_Intr_o;
  logic                 I2S_DMA_Intr_o;
  logic                 I2S_Dis_Intr_o;

  modport slave (
    input  I2S_CLK_i, I2S_WS_CLK_i, I2S_DIN_i,
    input  enable_i, mono_i, flush_i, ovf_clr_i,
    input  fifo_pop_i, SDMA_Done_i,
    output fifo_dat_o, fifo_lvl_o,
    output SDMA_Req_o, SDMA_Sreq_o,
    output I2S_RX_Intr_o, I2S_DMA_Intr_o, I2S_Dis_Intr_o
  );

  modport master (
    output I2S_CLK_i, I2S_WS_CLK_i, I2S_DIN_i,
    output enable_i, mono_i, flush_i, ovf_clr_i,
    output fifo_pop_i, SDMA_Done_i,
    input  fifo_dat_o, fifo_lvl_o,
    input  SDMA_Req_o, SDMA_Sreq_o,
    input  I2S_RX_Intr_o, I2S_DMA_Intr_o, I2S_Dis_Intr_o
  );
endinterface

// File: rtl/i2s_rx_multilane.sv
// Multilane I2S slave receiver, oversampled in WB_CLK.
// Sign-extended words land in a shared FWFT FIFO feeding SDMA.
module i2s_rx_multilane #(
  parameter int NUM_LANES  = 2,
  parameter int SAMPLE_W   = 24,
  parameter int FIFO_AW    = 6,
  parameter int DMA_THRESH = 16
) (
  input  logic WB_CLK,
  input  logic WB_RST,
  i2s_rx_multilane_if.slave bus
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [5:0] SW = 6'(SAMPLE_W);
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] THR = (FIFO_AW+1)'(DMA_THRESH);
  localparam logic [LW-1:0] LAST = LW'(NUM_LANES - 1);

  typedef enum logic [1:0] {IDLE, ALIGN, RUN, STOP} state_t;

  state_t               state;
  state_t               state_nx;
  logic [2:0]           sck_q;
  logic [1:0]           ws_q;
  logic [NUM_LANES-1:0] din_q1;
  logic [NUM_LANES-1:0] din_q2;
  logic                 ws_prev;
  logic                 edge_e;
  logic                 done_w;
  logic                 cap;
  logic                 cap_en;
  logic                 dis;
  logic [31:0]          acc  [NUM_LANES];
  logic [5:0]           cnt  [NUM_LANES];
  logic [31:0]          word [NUM_LANES];
  logic [31:0]          stg  [NUM_LANES];
  logic                 busy;
  logic [LW-1:0]        pidx;
  logic                 push;
  logic [31:0]          push_dat;
  logic [31:0]          mem  [DEPTH];
  logic [FIFO_AW-1:0]   wr;
  logic [FIFO_AW-1:0]   rd;
  logic [FIFO_AW:0]     count;
  logic                 full;
  logic                 push_ok;
  logic                 pop_ok;
  logic                 ovf_ev;
  logic                 ovf;
  logic                 dma_q;

  // Two-stage synchronizers plus one delay stage on SCK for edge detect
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      sck_q  <= '0;
      ws_q   <= '0;
      din_q1 <= '0;
      din_q2 <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], bus.I2S_CLK_i};
      ws_q   <= {ws_q[0], bus.I2S_WS_CLK_i};
      din_q1 <= bus.I2S_DIN_i;
      din_q2 <= din_q1;
    end
  end

  assign edge_e = sck_q[1] & ~sck_q[2];
  assign done_w = edge_e & (ws_q[1] != ws_prev);

  // Current word per lane including this edge's bit, first SAMPLE_W bits kept
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      word[k] = acc[k];
      if (din_q2[k] && (cnt[k] < SW))
        word[k] = acc[k] | (32'h8000_0000 >> cnt[k]);
    end
  end

  // Left-aligned bit accumulators and ws history
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      ws_prev <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        acc[k] <= '0;
        cnt[k] <= '0;
      end
    end else if (edge_e) begin
      ws_prev <= ws_q[1];
      for (int k = 0; k < NUM_LANES; k++) begin
        if (done_w) begin
          acc[k] <= '0;
          cnt[k] <= '0;
        end else begin
          acc[k] <= word[k];
          if (cnt[k] < SW)
            cnt[k] <= cnt[k] + 6'd1;
        end
      end
    end
  end

  assign cap = done_w & cap_en & ~(bus.mono_i & ws_prev);

  // Staging and lane-by-lane push sequencer
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      busy <= 1'b0;
      pidx <= '0;
      for (int k = 0; k < NUM_LANES; k++)
        stg[k] <= '0;
    end else begin
      if (busy) begin
        if (pidx == LAST)
          busy <= 1'b0;
        else
          pidx <= pidx + 1'b1;
      end
      if (cap) begin
        busy <= 1'b1;
        pidx <= '0;
        for (int k = 0; k < NUM_LANES; k++)
          stg[k] <= $unsigned($signed(word[k]) >>> (32 - SAMPLE_W));
      end
    end
  end

  assign push     = busy;
  assign push_dat = stg[pidx];

  // FSM state register
  always_ff @(posedge WB_CLK) begin
    if (WB_RST)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.enable_i) state_nx = ALIGN;
      ALIGN: begin
        if (!bus.enable_i)
          state_nx = STOP;
        else if (done_w && ws_prev && !ws_q[1])
          state_nx = RUN;
      end
      RUN:   if (!bus.enable_i) state_nx = STOP;
      STOP:  if (!busy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cap_en = (state == RUN);
    dis    = (state == STOP) && !busy;
  end

  assign full    = (count == FULL_LVL);
  assign pop_ok  = bus.fifo_pop_i & ((count != '0) | push);
  assign push_ok = push & (~full | bus.fifo_pop_i);
  assign ovf_ev  = push & full & ~bus.fifo_pop_i & ~bus.flush_i;

  // FIFO storage, no reset needed
  always_ff @(posedge WB_CLK) begin
    if (push_ok && !bus.flush_i)
      mem[wr] <= push_dat;
  end

  // FIFO pointers, level, overflow flag, DMA interrupt
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      dma_q <= 1'b0;
    end else begin
      dma_q <= bus.SDMA_Done_i;
      if (ovf_ev)
        ovf <= 1'b1;
      else if (bus.ovf_clr_i)
        ovf <= 1'b0;
      if (bus.flush_i) begin
        wr    <= '0;
        rd    <= '0;
        count <= '0;
      end else begin
        if (push_ok) wr <= wr + 1'b1;
        if (pop_ok)  rd <= rd + 1'b1;
        if (push_ok && !pop_ok)
          count <= count + 1'b1;
        else if (!push_ok && pop_ok)
          count <= count - 1'b1;
      end
    end
  end

  assign bus.fifo_dat_o     = (count != '0) ? mem[rd] : 32'h0;
  assign bus.fifo_lvl_o     = count;
  assign bus.SDMA_Req_o     = (count >= THR);
  assign bus.SDMA_Sreq_o    = (count != '0);
  assign bus.I2S_RX_Intr_o  = ovf;
  assign bus.I2S_DMA_Intr_o = dma_q;
  assign bus.I2S_Dis_Intr_o = dis;
endmodule

// File: tb/tb_i2s_rx_multilane.sv
// Bench for i2s_rx_multilane: vector table plus scoreboard.
// Corner sequences cover align, mono, overflow, flush, disable.
module tb_i2s_rx_multilane;
  logic WB_CLK = 1'b0;
  logic WB_RST = 1'b1;

  i2s_rx_multilane_if #(.NUM_LANES(2), .FIFO_AW(6)) bus ();

  i2s_rx_multilane #(
    .NUM_LANES(2), .SAMPLE_W(24), .FIFO_AW(6), .DMA_THRESH(16)
  ) dut (
    .WB_CLK(WB_CLK),
    .WB_RST(WB_RST),
    .bus(bus)
  );

  always #5 WB_CLK = ~WB_CLK;

  typedef struct {
    int slot;
    logic [31:0] l0, l1, r0, r1;
    logic [31:0] el0, el1, er0, er1;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] sb [$];
  int          total = 0;
  int          bad = 0;
  int          dis_cnt = 0;
  bit          drain = 0;
  bit          req_chk = 0;
  logic [6:0]  last_lvl = '0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fmt(logic [31:0] v, int slot);
    logic [23:0] s;
    if (slot >= 24) s = 24'(v >> (slot - 24));
    else            s = 24'(v << (24 - slot));
    return {{8{s[23]}}, s};
  endfunction

  always @(negedge WB_CLK) begin
    if (bus.I2S_Dis_Intr_o) dis_cnt++;
    if (req_chk && bus.fifo_lvl_o != last_lvl) begin
      if (bus.fifo_lvl_o == 7'd15)
        check("req_at15", 32'(bus.SDMA_Req_o), 32'd0);
      if (bus.fifo_lvl_o == 7'd16)
        check("req_at16", 32'(bus.SDMA_Req_o), 32'd1);
    end
    last_lvl = bus.fifo_lvl_o;
    if (drain && bus.fifo_lvl_o != '0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got %h want none", bus.fifo_dat_o);
      end else begin
        check("sb_data", bus.fifo_dat_o, sb.pop_front());
      end
      bus.fifo_pop_i = 1'b1;
    end else begin
      bus.fifo_pop_i = 1'b0;
    end
  end

  task automatic send_bits(bit lvl, logic [31:0] w0, logic [31:0] w1,
                           int slot, int from, int to);
    for (int i = from; i < to; i++) begin
      bus.I2S_CLK_i    = 1'b0;
      bus.I2S_WS_CLK_i = (i == slot - 1) ? ~lvl : lvl;
      bus.I2S_DIN_i    = {w1[slot-1-i], w0[slot-1-i]};
      #40;
      bus.I2S_CLK_i    = 1'b1;
      #40;
    end
  endtask

  task automatic send_frame(vec_t v, bit q_left, bit q_right);
    if (q_left) begin
      sb.push_back(v.el0);
      sb.push_back(v.el1);
    end
    send_bits(1'b0, v.l0, v.l1, v.slot, 0, v.slot);
    if (q_right) begin
      sb.push_back(v.er0);
      sb.push_back(v.er1);
    end
    send_bits(1'b1, v.r0, v.r1, v.slot, 0, v.slot);
  endtask

  task automatic wait_empty(string nm);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge WB_CLK);
      if (bus.fifo_lvl_o == '0 && sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    vec_t fv;
    int   d0;
    vecs[0] = '{32, 32'h12345600, 32'hABCDEF00, 32'h7FFFFF00, 32'h80000100,
                32'h00123456, 32'hFFABCDEF, 32'h007FFFFF, 32'hFF800001};
    vecs[1] = '{32, 32'h123456AB, 32'hFEDCBA99, 32'h00000001, 32'hFFFFFFFF,
                32'h00123456, 32'hFFFEDCBA, 32'h00000000, 32'hFFFFFFFF};
    vecs[2] = '{16, 32'h00008001, 32'h00001234, 32'h00007FFF, 32'h0000FFFF,
                32'hFF800100, 32'h00123400, 32'h007FFF00, 32'hFFFFFF00};
    vecs[3] = '{24, 32'h0000FF00, 32'h00800000, 32'h00123456, 32'h00FFFFFE,
                32'h0000FF00, 32'hFF800000, 32'h00123456, 32'hFFFFFFFE};
    vecs[4] = '{20, 32'h00080001, 32'h00012345, 32'h000FFFFF, 32'h00000001,
                32'hFF800010, 32'h00123450, 32'hFFFFFFF0, 32'h00000010};

    bus.I2S_CLK_i = 0; bus.I2S_WS_CLK_i = 0; bus.I2S_DIN_i = '0;
    bus.enable_i = 0; bus.mono_i = 0; bus.flush_i = 0;
    bus.ovf_clr_i = 0; bus.fifo_pop_i = 0; bus.SDMA_Done_i = 0;
    WB_RST = 1'b1;
    repeat (3) @(negedge WB_CLK);
    WB_RST = 1'b0;
    @(negedge WB_CLK);
    check("rst_dat", bus.fifo_dat_o, 32'h0);
    check("rst_lvl", 32'(bus.fifo_lvl_o), 32'd0);
    check("rst_req", 32'(bus.SDMA_Req_o), 32'd0);
    check("rst_sreq", 32'(bus.SDMA_Sreq_o), 32'd0);
    check("rst_ovf", 32'(bus.I2S_RX_Intr_o), 32'd0);
    check("rst_dma", 32'(bus.I2S_DMA_Intr_o), 32'd0);
    check("rst_dis", 32'(bus.I2S_Dis_Intr_o), 32'd0);

    bus.enable_i = 1'b1;
    repeat (4) @(negedge WB_CLK);
    drain = 1;
    send_bits(1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 32, 0, 32);
    for (int i = 0; i < 5; i++) send_frame(vecs[i], 1, 1);
    wait_empty("vec_drain");

    @(negedge WB_CLK);
    check("dma_idle", 32'(bus.I2S_DMA_Intr_o), 32'd0);
    bus.SDMA_Done_i = 1'b1;
    @(negedge WB_CLK);
    check("dma_pulse", 32'(bus.I2S_DMA_Intr_o), 32'd1);
    bus.SDMA_Done_i = 1'b0;
    @(negedge WB_CLK);
    check("dma_clear", 32'(bus.I2S_DMA_Intr_o), 32'd0);

    d0 = dis_cnt;
    bus.enable_i = 1'b0;
    repeat (10) @(negedge WB_CLK);
    check("dis_once", 32'(dis_cnt - d0), 32'd1);

    send_bits(1'b0, 32'h11111111, 32'h22222222, 32, 0, 32);
    send_bits(1'b1, 32'h33333333, 32'h44444444, 32, 0, 12);
    bus.enable_i = 1'b1;
    repeat (4) @(negedge WB_CLK);
    send_bits(1'b1, 32'h33333333, 32'h44444444, 32, 12, 32);
    send_frame(vecs[0], 1, 1);
    wait_empty("align_drain");

    drain = 0;
    bus.mono_i = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(vecs[3], 1, 0);
    repeat (10) @(negedge WB_CLK);
    check("mono_lvl", 32'(bus.fifo_lvl_o), 32'd8);
    drain = 1;
    wait_empty("mono_drain");
    bus.mono_i = 1'b0;

    drain = 0;
    req_chk = 1;
    for (int i = 0; i < 17; i++) begin
      fv.slot = 32;
      fv.l0 = {8'(i), 24'h5A5A5A};
      fv.l1 = ~fv.l0;
      fv.r0 = fv.l0 ^ 32'h00FF00FF;
      fv.r1 = {8'(8'h80 | 8'(i)), 24'h0F0F0F};
      fv.el0 = fmt(fv.l0, 32);
      fv.el1 = fmt(fv.l1, 32);
      fv.er0 = fmt(fv.r0, 32);
      fv.er1 = fmt(fv.r1, 32);
      send_frame(fv, i < 16, i < 16);
      if (i == 15) begin
        repeat (10) @(negedge WB_CLK);
        check("full_lvl", 32'(bus.fifo_lvl_o), 32'd64);
        check("full_noovf", 32'(bus.I2S_RX_Intr_o), 32'd0);
      end
    end
    repeat (10) @(negedge WB_CLK);
    req_chk = 0;
    check("ovf_lvl", 32'(bus.fifo_lvl_o), 32'd64);
    check("ovf_set", 32'(bus.I2S_RX_Intr_o), 32'd1);
    check("full_req", 32'(bus.SDMA_Req_o), 32'd1);
    check("full_sreq", 32'(bus.SDMA_Sreq_o), 32'd1);
    bus.ovf_clr_i = 1'b1;
    @(negedge WB_CLK);
    bus.ovf_clr_i = 1'b0;
    check("ovf_clr", 32'(bus.I2S_RX_Intr_o), 32'd0);
    drain = 1;
    wait_empty("fill_drain");

    drain = 0;
    send_frame(vecs[1], 0, 0);
    repeat (10) @(negedge WB_CLK);
    check("pre_flush_lvl", 32'(bus.fifo_lvl_o), 32'd4);
    bus.flush_i = 1'b1;
    @(negedge WB_CLK);
    bus.flush_i = 1'b0;
    check("flush_lvl", 32'(bus.fifo_lvl_o), 32'd0);
    check("flush_dat", bus.fifo_dat_o, 32'h0);

    drain = 1;
    d0 = dis_cnt;
    send_bits(1'b0, 32'hFFFFFFFF, 32'h0F0F0F0F, 32, 0, 10);
    bus.enable_i = 1'b0;
    repeat (20) @(negedge WB_CLK);
    send_bits(1'b0, 32'hFFFFFFFF, 32'h0F0F0F0F, 32, 10, 32);
    repeat (10) @(negedge WB_CLK);
    check("stop_dis", 32'(dis_cnt - d0), 32'd1);
    check("stop_lvl", 32'(bus.fifo_lvl_o), 32'd0);
    check("stop_sb", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
